fixed_unsigned_cast_sequencer: RTL

//  Streams a vector of BLOCK_SIZE unsigned fixed-point elements through LANES shared cast lanes.

---
 rtl/fixed_unsigned_cast_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fixed_unsigned_cast_sequencer.sv
// Vector cast sequencer: streams BLOCK_SIZE unsigned fixed-point elements through
// LANES shared floor/saturate cast lanes and returns the full vector on valid/ready.
module fixed_unsigned_cast_sequencer #(
    parameter int unsigned IN_WIDTH       = 8,
    parameter int unsigned IN_FRAC_WIDTH  = 4,
    parameter int unsigned OUT_WIDTH      = 8,
    parameter int unsigned OUT_FRAC_WIDTH = 4,
    parameter int unsigned BLOCK_SIZE     = 8,
    parameter int unsigned LANES          = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [BLOCK_SIZE*IN_WIDTH-1:0]  data_in,
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    output logic [BLOCK_SIZE*OUT_WIDTH-1:0] data_out,
    output logic                            data_out_valid,
    input  logic                            data_out_ready,
    output logic                            busy
);

    localparam int unsigned BEATS = BLOCK_SIZE / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int          SHIFT = int'(OUT_FRAC_WIDTH) - int'(IN_FRAC_WIDTH);
    localparam int unsigned LSH   = (SHIFT > 0) ? SHIFT : 0;
    localparam int unsigned RSH   = (SHIFT < 0) ? -SHIFT : 0;
    localparam int unsigned MAXW  = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
    localparam int unsigned WIDE  = MAXW + LSH;

    // Lane count must tile the vector exactly
    if (BLOCK_SIZE % LANES != 0) begin : g_bad_lanes
        $error("BLOCK_SIZE must be a multiple of LANES");
    end

    typedef enum logic [1:0] {IDLE, CAST, OUT} state_t;

    state_t                          state;
    state_t                          state_next;
    logic [BLOCK_SIZE*IN_WIDTH-1:0]  in_buf;
    logic [BLOCK_SIZE*OUT_WIDTH-1:0] out_buf;
    logic [CNT_W-1:0]                beat;
    logic                            last_beat;
    logic                            accept;
    logic [OUT_WIDTH-1:0]            lane_res [LANES];

    assign last_beat = (beat == CNT_W'(BEATS - 1));
    assign accept    = data_in_valid & data_in_ready;
    assign data_out  = out_buf;

    // Cast lanes: widen, align binary point with floor, saturate on overflow
    for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
        logic [IN_WIDTH-1:0] x;
        logic [WIDE-1:0]     v;
        logic                sat;

        assign x   = in_buf[(int'(beat) * int'(LANES) + l) * int'(IN_WIDTH) +: IN_WIDTH];
        assign v   = (WIDE'(x) << LSH) >> RSH;
        assign sat = |(v >> OUT_WIDTH);
        assign lane_res[l] = sat ? {OUT_WIDTH{1'b1}} : v[OUT_WIDTH-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (data_in_valid) begin
                    state_next = CAST;
                end
            end
            CAST: begin
                if (last_beat) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (data_out_ready) begin
                    state_next = data_in_valid ? CAST : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode; input ready passes data_out_ready through for back-to-back vectors
    always_comb begin
        data_in_ready  = 1'b0;
        data_out_valid = 1'b0;
        busy           = 1'b0;
        case (state)
            IDLE: data_in_ready = ~rst;
            CAST: busy = 1'b1;
            OUT: begin
                busy           = 1'b1;
                data_out_valid = 1'b1;
                data_in_ready  = ~rst & data_out_ready;
            end
            default: begin
                data_in_ready  = 1'b0;
                data_out_valid = 1'b0;
                busy           = 1'b0;
            end
        endcase
    end

    // Datapath: capture input vector, step beats, gather lane results
    always_ff @(posedge clk) begin
        if (rst) begin
            in_buf  <= '0;
            out_buf <= '0;
            beat    <= '0;
        end else if (accept) begin
            in_buf <= data_in;
            beat   <= '0;
        end else if (state == CAST) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                out_buf[(int'(beat) * int'(LANES) + int'(l)) * int'(OUT_WIDTH) +: OUT_WIDTH] <= lane_res[l];
            end
            if (!last_beat) begin
                beat <= beat + CNT_W'(1);
            end
        end
    end

endmodule
